// File: rtl/trng_bit_collector.sv
// Raw entropy bit collector: packs sampled bits into 5-bit S-box words.
// Optional repetition-count health test enabled by macro TRNG_HEALTH_EN.
module trng_bit_collector #(
    parameter int REP_LIMIT = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic        raw_bit,
    output logic [4:0]  sbox_in,
    output logic        activate_sbox,
    output logic        health_fail,
    output logic [15:0] word_count
);

`ifdef TRNG_HEALTH_EN
    typedef enum logic [1:0] {IDLE, COLLECT, FAIL} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

    state_t     state;
    logic [2:0] bit_cnt;
    logic [3:0] sr;
    logic       accept;
    logic       last_bit;
    logic [4:0] word;

    generate
        if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_rep_limit
            $error("REP_LIMIT must be in 2..255");
        end
    endgenerate

    assign accept   = sample_valid && enable && (state == COLLECT);
    assign last_bit = (bit_cnt == 3'd4);
    assign word     = {sr, raw_bit};

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] RMAX = RW'(REP_LIMIT);

    logic [RW-1:0] run;
    logic [RW-1:0] run_next;
    logic          rep_hit;
    logic          fail_q;

    // sr[0] is the previous accepted bit whenever run is non-zero
    always_comb begin
        run_next = RW'(1);
        if (run != '0 && raw_bit == sr[0]) begin
            run_next = (run == RMAX) ? run : run + 1'b1;
        end
    end

    assign rep_hit     = accept && (run_next == RMAX);
    assign health_fail = fail_q;
`else
    assign health_fail = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            sr            <= '0;
            sbox_in       <= '0;
            activate_sbox <= 1'b0;
            word_count    <= '0;
`ifdef TRNG_HEALTH_EN
            run           <= '0;
            fail_q        <= 1'b0;
`endif
        end else begin
            activate_sbox <= 1'b0;
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    sr      <= '0;
`ifdef TRNG_HEALTH_EN
                    run     <= '0;
`endif
                    if (enable) begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!enable) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        sr      <= '0;
`ifdef TRNG_HEALTH_EN
                        run     <= '0;
                    end else if (rep_hit) begin
                        // failure beats a word completing on the same bit
                        state   <= FAIL;
                        fail_q  <= 1'b1;
                        sbox_in <= '0;
`endif
                    end else if (accept) begin
                        sr <= word[3:0];
`ifdef TRNG_HEALTH_EN
                        run <= run_next;
`endif
                        if (last_bit) begin
                            bit_cnt       <= '0;
                            sbox_in       <= word;
                            activate_sbox <= 1'b1;
                            word_count    <= word_count + 16'd1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef TRNG_HEALTH_EN
                FAIL: begin
                    state <= FAIL;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_bit_collector.sv
// Scoreboard bench for trng_bit_collector; words queued at stimulus,
// popped on each activate_sbox pulse. Health test runs under TRNG_HEALTH_EN.
module tb_trng_bit_collector;

    localparam int REP = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic        raw_bit = 1'b0;
    logic [4:0]  sbox_in;
    logic        activate_sbox;
    logic        health_fail;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  word;
        logic [15:0] count;
    } exp_t;

    exp_t sb[$];
    int   pulses = 0;
    logic prev_act = 1'b0;

    logic [4:0]  m_sr;
    int          m_cnt;
    logic [15:0] m_words;
    int          m_run;
    logic        m_prev;
    logic        m_fail;

    always #5 clk = ~clk;

    trng_bit_collector #(.REP_LIMIT(REP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .sample_valid(sample_valid),
        .raw_bit(raw_bit),
        .sbox_in(sbox_in),
        .activate_sbox(activate_sbox),
        .health_fail(health_fail),
        .word_count(word_count)
    );

    // pulse monitor: every pulse must match the oldest queued word
    always @(negedge clk) begin
        exp_t e;
        if (activate_sbox) begin
            pulses++;
            checks++;
            if (prev_act) begin
                errors++;
                $display("FAIL adjacent_pulse: activate_sbox high 2 cycles, required 1");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: sbox_in=%b word_count=%0d, none expected",
                         sbox_in, word_count);
            end else begin
                e = sb.pop_front();
                if (sbox_in !== e.word || word_count !== e.count) begin
                    errors++;
                    $display("FAIL word: sbox_in=%b cnt=%0d, required %b cnt=%0d",
                             sbox_in, word_count, e.word, e.count);
                end
            end
        end
        prev_act = activate_sbox;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        m_sr  = '0;
        m_cnt = 0;
        m_run = 0;
        m_prev = 1'b0;
    endtask

    task automatic apply_reset();
        enable = 1'b0;
        sample_valid = 1'b0;
        rst_n = 1'b1;
        tick(2);
        rst_n = 1'b0;
        model_clear();
        m_words = '0;
        m_fail  = 1'b0;
        sb.delete();
        pulses = 0;
    endtask

    task automatic send_bit(input logic b);
        exp_t e;
        sample_valid = 1'b1;
        raw_bit = b;
        tick(1);
        sample_valid = 1'b0;
        if (!m_fail) begin
`ifdef TRNG_HEALTH_EN
            if (m_run == 0 || b != m_prev) m_run = 1;
            else if (m_run < REP) m_run++;
            m_prev = b;
            if (m_run == REP) m_fail = 1'b1;
`endif
            if (!m_fail) begin
                m_sr = {m_sr[3:0], b};
                m_cnt++;
                if (m_cnt == 5) begin
                    m_cnt = 0;
                    m_words++;
                    e.word = m_sr;
                    e.count = m_words;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (sbox_in !== 5'd0 || activate_sbox !== 1'b0 ||
            health_fail !== 1'b0 || word_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: sbox=%b act=%b hf=%b cnt=%0d, required all 0",
                     sbox_in, activate_sbox, health_fail, word_count);
        end
        enable = 1'b1;
        tick(1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        // mid-word, with sbox_in and word_count non-zero
        rst_n = 1'b1;
        #1;
        checks++;
        if (sbox_in !== 5'd0 || activate_sbox !== 1'b0 ||
            health_fail !== 1'b0 || word_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: sbox=%b act=%b hf=%b cnt=%0d, required all 0",
                     sbox_in, activate_sbox, health_fail, word_count);
        end
        tick(1);
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            sample_valid = i[0];
            raw_bit = i[1];
            @(negedge clk);
            checks++;
            if (sbox_in !== 5'd0 || activate_sbox !== 1'b0 || word_count !== 16'd0) begin
                errors++;
                $display("FAIL idle_hold: sbox=%b act=%b cnt=%0d, required 0",
                         sbox_in, activate_sbox, word_count);
            end
        end
        sample_valid = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        apply_reset();
        enable = 1'b1;
        sample_valid = 1'b1;
        raw_bit = 1'b0;
        tick(1);
        sample_valid = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0);
        @(negedge clk);
        checks++;
        if (activate_sbox !== 1'b1 || sbox_in !== 5'b10110 || word_count !== 16'd1) begin
            errors++;
            $display("FAIL basic_word: act=%b sbox=%b cnt=%0d, required 1 10110 1",
                     activate_sbox, sbox_in, word_count);
        end
        @(negedge clk);
        checks++;
        if (activate_sbox !== 1'b0 || sbox_in !== 5'b10110) begin
            errors++;
            $display("FAIL basic_pulse_end: act=%b sbox=%b, required 0 10110",
                     activate_sbox, sbox_in);
        end
        tick(3);
        checks++;
        if (pulses !== 1 || sb.size() !== 0) begin
            errors++;
            $display("FAIL basic_count: pulses=%0d pending=%0d, required 1 0",
                     pulses, sb.size());
        end
    endtask

    task automatic test_gapped();
        logic [4:0] pat;
        pat = 5'b10110;
        apply_reset();
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            send_bit(pat[4-i]);
            if (i < 4) begin
                tick($urandom_range(0, 3));
                checks++;
                if (pulses !== 0) begin
                    errors++;
                    $display("FAIL gapped_early: pulses=%0d after bit %0d, required 0",
                             pulses, i + 1);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (activate_sbox !== 1'b1 || sbox_in !== 5'b10110 || word_count !== 16'd1) begin
            errors++;
            $display("FAIL gapped_word: act=%b sbox=%b cnt=%0d, required 1 10110 1",
                     activate_sbox, sbox_in, word_count);
        end
        tick(3);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL gapped_count: pulses=%0d, required 1", pulses);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        enable = 1'b1;
        tick(1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        // bit coinciding with enable falling is not accepted
        enable = 1'b0;
        sample_valid = 1'b1;
        raw_bit = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        model_clear();
        tick(1);
        enable = 1'b1;
        tick(1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1);
        tick(3);
        checks++;
        if (sbox_in !== 5'b01001 || word_count !== 16'd1 || pulses !== 1) begin
            errors++;
            $display("FAIL abort: sbox=%b cnt=%0d pulses=%0d, required 01001 1 1",
                     sbox_in, word_count, pulses);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            send_bit(1'($urandom_range(0, 1)));
        end
        tick(3);
        checks++;
        if (pulses !== 4 || word_count !== 16'd4 || sb.size() !== 0) begin
            errors++;
            $display("FAIL back_to_back: pulses=%0d cnt=%0d pending=%0d, required 4 4 0",
                     pulses, word_count, sb.size());
        end
    endtask

`ifdef TRNG_HEALTH_EN
    task automatic test_health();
        apply_reset();
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < REP; i++) begin
            send_bit(1'b1);
        end
        checks++;
        if (health_fail !== 1'b1 || sbox_in !== 5'd0) begin
            errors++;
            $display("FAIL health_trip: hf=%b sbox=%b, required 1 00000",
                     health_fail, sbox_in);
        end
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b1);
        end
        tick(2);
        checks++;
        if (pulses !== 6 || word_count !== 16'd6 || health_fail !== 1'b1) begin
            errors++;
            $display("FAIL health_hold: pulses=%0d cnt=%0d hf=%b, required 6 6 1",
                     pulses, word_count, health_fail);
        end
        apply_reset();
        checks++;
        if (health_fail !== 1'b0) begin
            errors++;
            $display("FAIL health_clear: hf=%b, required 0", health_fail);
        end
    endtask
`else
    task automatic test_no_health();
        int hf_seen;
        hf_seen = 0;
        apply_reset();
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < 40; i++) begin
            send_bit(1'b1);
            if (health_fail !== 1'b0) hf_seen++;
        end
        tick(2);
        checks++;
        if (pulses !== 8 || word_count !== 16'd8 ||
            sbox_in !== 5'b11111 || hf_seen !== 0) begin
            errors++;
            $display("FAIL no_health: pulses=%0d cnt=%0d sbox=%b hf_cycles=%0d, req 8 8 11111 0",
                     pulses, word_count, sbox_in, hf_seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_abort();
        test_back_to_back();
`ifdef TRNG_HEALTH_EN
        test_health();
`else
        test_no_health();
`endif
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words pending, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_bit_collector.md
# trng_bit_collector

Upstream stage of the TRNG conditioning path. Gathers sampled raw entropy bits into 5-bit words and issues each word to the Ascon S-box stage with a one-cycle activate strobe. Runs an optional repetition-count health test on the raw stream and latches a sticky failure that stops word issue.

## Interface
Parameters:
- REP_LIMIT, 31: repetition-count cutoff, legal range 2..255. A run of REP_LIMIT identical accepted bits is a health failure.

Ports (all outputs registered):
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous and active-high (asserted = 1) despite the name.
- enable  input  1  collection enable.
- sample_valid  input  1  one-cycle strobe marking a new raw_bit; already synchronous to clk.
- raw_bit  input  1  sampled entropy bit, qualified by sample_valid.
- sbox_in  output  5  last completed word, feeds the S-box data input.
- activate_sbox  output  1  one-cycle pulse per issued word, feeds the S-box activate input.
- health_fail  output  1  sticky repetition-test failure.
- word_count  output  16  number of issued words, wraps 0xFFFF -> 0x0000.

## Operation
- An accepted bit is a cycle with sample_valid=1, enable=1, state COLLECT.
- FSM states:
  - IDLE: entered from reset and whenever enable=0 outside FAIL. Bit counter, shift register and run counter are cleared. sbox_in and word_count hold. IDLE -> COLLECT when enable=1.
  - COLLECT: shift register does sr <= {sr[3:0], raw_bit} on each accepted bit. The first bit of a word ends up in sbox_in[4]. Bit counter counts 0..4. When an accepted bit is the 5th: load sbox_in <= {sr[3:0], raw_bit}, pulse activate_sbox, word_count += 1, bit counter -> 0. enable=0 -> IDLE and the partial word is discarded.
  - FAIL: health_fail=1, activate_sbox=0, sbox_in=5'b00000. All inputs are ignored. The only exit is reset.
- Repetition counter, width clog2(REP_LIMIT+1):
  - First accepted bit after IDLE sets run=1.
  - Bit equal to the previous accepted bit: run += 1, saturating.
  - Different bit: run=1.
  - When run reaches REP_LIMIT: next state FAIL.
- Simultaneous events:
  - If the failing bit also completes a word, FAIL wins: no pulse, no load, no word_count increment.
  - enable falling in the same cycle as an accepted bit: that bit is not accepted, since enable=0 disqualifies it.
- The run counter is continuous across word boundaries. It is cleared only on IDLE entry and reset.

## Timing
- Reset values: sbox_in=0, activate_sbox=0, health_fail=0, word_count=0, state IDLE.
- Reset asserted mid-word or in FAIL returns everything to reset values asynchronously.
- 5th bit accepted at cycle N:
  - Cycle N+1: sbox_in holds the new word, activate_sbox=1 for exactly that cycle, and word_count is updated.
  - The S-box stage registers the strobe, so its output is valid at N+2.
  - sbox_in stays stable until the next word load, which is at least 5 cycles later. This meets the S-box hold requirement.
- Back-to-back sample_valid gives one word per 5 cycles; pulses are never adjacent.
- Failure on the bit accepted at cycle N: health_fail=1 and sbox_in=0 at N+1.
- IDLE -> COLLECT takes one cycle after enable rises. A sample_valid in that first cycle (still IDLE) is dropped.

## Configuration
- Macro TRNG_HEALTH_EN.
- Defined: the repetition counter and FAIL state are implemented as described above.
- Undefined: no repetition counter and no FAIL state. health_fail is tied to 0 and collection never stops on run length. REP_LIMIT is unused.

## Test plan
- Reset: pulse rst_n high mid-operation. All outputs must be 0 immediately (asynchronous) and stay 0 with enable=0 and sample_valid toggling.
- Basic word: enable=1, wait one cycle, then bits 1,0,1,1,0 on consecutive sample_valid cycles. One cycle after the 5th bit: sbox_in=5'b10110, activate_sbox high for one cycle, word_count=1.
- Gapped samples: the same bits with 0-3 idle cycles between strobes. Required: no pulse before the 5th bit, then the same word and pulse timing relative to the 5th bit.
- Abort: 3 bits, then enable=0 for 2 cycles, then re-enable and send 0,1,0,0,1. Required: sbox_in=5'b01001, word_count=1, with exactly one pulse overall.
- Health fail (TRNG_HEALTH_EN, REP_LIMIT=31): 31 consecutive ones. Required:
  - 6 pulses, each with sbox_in=5'b11111.
  - health_fail=1 and sbox_in=0 one cycle after the 31st bit.
  - No pulses on a further 20 bits; reset clears the failure.
- Macro off: 40 consecutive ones. Required: 8 pulses, sbox_in=5'b11111, health_fail=0 throughout, word_count=8.
